uart_rx_module: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the existing serial transmitter; same clock domain and baud divisor convention.
- Samples the asynchronous rxd pin, recovers bytes and presents them with a one-cycle rx_flag strobe.
- rx_flag/rx_data feed the transmitter's rx_flag/tx_data inputs directly for loopback/echo.
- Also reports framing errors and a busy indication to the host-command logic.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 39 +++
 rtl/uart_rx_module.sv | 148 ++++++++++++++
 tb/tb_uart_rx_module.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divisor, 8N1 frame constants,
// the 2-bit state encoding and a 2-of-3 majority helper. The transmitter can
// reuse the same package.
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 1216;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // 2-of-3 majority vote
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Front end of the receiver. It brings the asynchronous rxd pin into the clock
// domain, flags falling edges and forms a 3-sample majority vote around the
// sample point. The vote covers the synchronised line one cycle before the
// tick, at the tick and one cycle after, so it is valid in the cycle after the tick.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rxd,
    output logic o_rxd_s,
    output logic o_fall,
    output logic o_vote
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_d;
    logic [1:0]             r_hist;

    // Synchroniser chain, edge-detect delay flop and sample history; all idle high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '1;
            r_rxd_d <= 1'b1;
            r_hist  <= 2'b11;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_rxd};
            r_rxd_d <= o_rxd_s;
            r_hist  <= {r_hist[0], o_rxd_s};
        end
    end

    assign o_rxd_s = r_sync[SYNC_STAGES-1];
    assign o_fall  = r_rxd_d & ~o_rxd_s;
    assign o_vote  = majority3(r_hist[1], r_hist[0], o_rxd_s);

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver. The receiver synchronises rxd, waits for the start-bit
// centre and samples each bit with a majority vote. It presents the byte
// with a one-cycle rx_flag, or flags a low stop bit with a one-cycle rx_err.
// It returns to IDLE at the stop-bit centre, so frames with no idle time
// between them are still received.
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = BAUD_DIV_DEFAULT,
    parameter int HALF_DIV    = BAUD_DIV / 2,
    parameter int SYNC_STAGES = 2
)(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic [7:0] o_rx_data,
    output logic       o_rx_flag,
    output logic       o_rx_err,
    output logic       o_rx_busy
);

    localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    logic        w_fall;
    logic        w_vote;
    logic        w_rxd_s;
    logic        w_tick;
    uart_state_t r_state;
    uart_state_t w_next_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shreg;
    logic [7:0]  r_rx_data;
    logic        r_rx_flag;
    logic        r_rx_err;
    logic        r_tick_d;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_rxd   (i_rxd),
        .o_rxd_s (w_rxd_s),
        .o_fall  (w_fall),
        .o_vote  (w_vote)
    );

    // Sample tick: half a bit into START, a full bit period in DATA and STOP
    always_comb begin
        w_tick = 1'b0;
        case (r_state)
            ST_START: w_tick = (r_baud_cnt == HALF_LAST);
            ST_DATA,
            ST_STOP:  w_tick = (r_baud_cnt == BAUD_LAST);
            default:  w_tick = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; decisions are taken on the vote, one cycle after each tick
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_fall) w_next_state = ST_START;
            ST_START: if (r_tick_d) w_next_state = (w_vote == START_LVL) ? ST_DATA : ST_IDLE;
            ST_DATA:  if (r_tick_d && (r_bit_idx == LAST_BIT)) w_next_state = ST_STOP;
            ST_STOP:  if (r_tick_d) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: busy for the whole frame, from start detection to the stop decision
    always_comb begin
        o_rx_busy = 1'b0;
        if (r_state != ST_IDLE) o_rx_busy = 1'b1;
    end

    // Bit timer, data shift register and result strobes. The counter is
    // loaded with 1 when DATA or STOP is entered because the vote cycle
    // has already used one cycle of the new bit. This keeps every sample
    // exactly one bit period after the previous one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            r_rx_data  <= 8'h00;
            r_rx_flag  <= 1'b0;
            r_rx_err   <= 1'b0;
            r_tick_d   <= 1'b0;
        end else begin
            r_rx_flag <= 1'b0;
            r_rx_err  <= 1'b0;
            r_tick_d  <= w_tick;

            if (w_next_state != r_state) begin
                if ((w_next_state == ST_DATA) || (w_next_state == ST_STOP)) begin
                    r_baud_cnt <= 16'd1;
                end else begin
                    r_baud_cnt <= '0;
                end
            end else if (r_state == ST_IDLE) begin
                r_baud_cnt <= '0;
            end else if (w_tick && (r_state != ST_START)) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end

            if (r_tick_d) begin
                case (r_state)
                    ST_START: begin
                        if (w_vote == START_LVL) r_bit_idx <= '0;
                    end
                    ST_DATA: begin
                        r_shreg   <= {w_vote, r_shreg[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    ST_STOP: begin
                        if (w_vote == STOP_LVL) begin
                            r_rx_data <= r_shreg;
                            r_rx_flag <= 1'b1;
                        end else begin
                            r_rx_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_rx_data = r_rx_data;
    assign o_rx_flag = r_rx_flag;
    assign o_rx_err  = r_rx_err;

endmodule

// File: tb/tb_uart_rx_module.sv
// Testbench for uart_rx_module. Frames are driven as plain bit sequences.
// The expected events (byte or framing error, held data value and cycle of
// the strobe) come from the 8N1 frame rules and the stated latency formula.
module tb_uart_rx_module;

    localparam int B   = 16;
    localparam int H   = B / 2;
    localparam int S   = 2;
    localparam int LAT = (19 * B) / 2 + S + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rxData;
    logic       rxFlag;
    logic       rxErr;
    logic       rxBusy;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t        obsQ[$];
    ev_t        expQ[$];
    logic [7:0] lastGood = 8'h00;
    int         testsRun = 0;
    int         testsFailed = 0;
    int         bothHigh = 0;
    int         busyCycles = 0;
    int         spuriousData = 0;
    int         cyc = 0;
    logic       rstAtEdge = 1'b1;
    logic [7:0] prevData = 8'h00;

    // Free-running clock
    always #5 clk = ~clk;

    uart_rx_module #(
        .BAUD_DIV    (B),
        .HALF_DIV    (H),
        .SYNC_STAGES (S)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_rxd     (rxd),
        .o_rx_data (rxData),
        .o_rx_flag (rxFlag),
        .o_rx_err  (rxErr),
        .o_rx_busy (rxBusy)
    );

    // Cycle counter and a record of whether reset was applied at the last edge
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rstAtEdge <= rst;
    end

    // Monitor on the falling edge: log strobes, check exclusivity and data holding
    always @(negedge clk) begin
        if (!rstAtEdge) begin
            if (rxFlag) obsQ.push_back('{1'b0, rxData, cyc});
            if (rxErr)  obsQ.push_back('{1'b1, rxData, cyc});
            if (rxFlag && rxErr) bothHigh++;
            if (rxBusy) busyCycles++;
            if ((rxData !== prevData) && !rxFlag) spuriousData++;
        end
        prevData = rxData;
    end

    // Hold the line at a level for n cycles, returning just after a rising edge
    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the event an 8N1 frame starting at startCyc must produce
    task automatic expectFrame(input logic [7:0] d, input logic stopLvl, input int startCyc);
        ev_t e;
        e.isErr = !stopLvl;
        e.cyc   = startCyc + LAT;
        if (stopLvl) begin
            lastGood = d;
        end
        e.data = lastGood;
        expQ.push_back(e);
    endtask

    // Drive a full 8N1 frame, LSB first, with the given stop level
    task automatic applyStimulus(input logic [7:0] d, input logic stopLvl);
        int startCyc;
        startCyc = cyc;
        hold(1'b0, B);
        for (int i = 0; i < 8; i++) hold(d[i], B);
        hold(stopLvl, B);
        expectFrame(d, stopLvl, startCyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (rxData !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset rx_data: got %h expected 00", rxData); end
        testsRun++;
        if (rxFlag !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset rx_flag: got %b expected 0", rxFlag); end
        testsRun++;
        if (rxErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset rx_err: got %b expected 0", rxErr); end
        testsRun++;
        if (rxBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset rx_busy: got %b expected 0", rxBusy); end
        rst = 1'b0;
        hold(1'b1, 2 * B);
    endtask

    task automatic test_single_byte();
        obsQ.delete(); expQ.delete();
        applyStimulus(8'hA5, 1'b1);
        hold(1'b1, 2 * B);
        testsRun++;
        if (obsQ.size() !== expQ.size()) begin testsFailed++; $display("[TB] FAIL single event count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            testsRun++;
            if (obsQ[i].isErr !== expQ[i].isErr || obsQ[i].data !== expQ[i].data || obsQ[i].cyc !== expQ[i].cyc) begin
                testsFailed++;
                $display("[TB] FAIL single event %0d: got err=%0d data=%h cyc=%0d expected err=%0d data=%h cyc=%0d",
                         i, obsQ[i].isErr, obsQ[i].data, obsQ[i].cyc, expQ[i].isErr, expQ[i].data, expQ[i].cyc);
            end
        end
        testsRun++;
        if (rxData !== 8'hA5) begin testsFailed++; $display("[TB] FAIL single held data: got %h expected a5", rxData); end
        testsRun++;
        if (rxBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single busy after: got %b expected 0", rxBusy); end
    endtask

    task automatic test_framing_break();
        obsQ.delete(); expQ.delete();
        applyStimulus(8'h3C, 1'b0);
        hold(1'b0, 30 * B);
        hold(1'b1, 2 * B);
        applyStimulus(8'h5A, 1'b1);
        hold(1'b1, 2 * B);
        testsRun++;
        if (obsQ.size() !== expQ.size()) begin testsFailed++; $display("[TB] FAIL framing event count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            testsRun++;
            if (obsQ[i].isErr !== expQ[i].isErr || obsQ[i].data !== expQ[i].data || obsQ[i].cyc !== expQ[i].cyc) begin
                testsFailed++;
                $display("[TB] FAIL framing event %0d: got err=%0d data=%h cyc=%0d expected err=%0d data=%h cyc=%0d",
                         i, obsQ[i].isErr, obsQ[i].data, obsQ[i].cyc, expQ[i].isErr, expQ[i].data, expQ[i].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        obsQ.delete(); expQ.delete();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        hold(1'b1, 2 * B);
        testsRun++;
        if (obsQ.size() !== expQ.size()) begin testsFailed++; $display("[TB] FAIL b2b event count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            testsRun++;
            if (obsQ[i].isErr !== expQ[i].isErr || obsQ[i].data !== expQ[i].data || obsQ[i].cyc !== expQ[i].cyc) begin
                testsFailed++;
                $display("[TB] FAIL b2b event %0d: got err=%0d data=%h cyc=%0d expected err=%0d data=%h cyc=%0d",
                         i, obsQ[i].isErr, obsQ[i].data, obsQ[i].cyc, expQ[i].isErr, expQ[i].data, expQ[i].cyc);
            end
        end
        if (obsQ.size() >= 2) begin
            testsRun++;
            if (obsQ[1].cyc - obsQ[0].cyc !== 10 * B) begin
                testsFailed++;
                $display("[TB] FAIL b2b spacing: got %0d expected %0d", obsQ[1].cyc - obsQ[0].cyc, 10 * B);
            end
        end
    endtask

    task automatic test_glitch();
        obsQ.delete(); expQ.delete();
        busyCycles = 0;
        hold(1'b0, 4);
        hold(1'b1, 3 * B);
        testsRun++;
        if (obsQ.size() !== 0) begin testsFailed++; $display("[TB] FAIL glitch strobes: got %0d expected 0", obsQ.size()); end
        testsRun++;
        if (busyCycles < H || busyCycles > H + 3) begin
            testsFailed++;
            $display("[TB] FAIL glitch busy cycles: got %0d expected %0d..%0d", busyCycles, H, H + 3);
        end
        testsRun++;
        if (rxBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL glitch busy after: got %b expected 0", rxBusy); end
    endtask

    task automatic test_spike();
        logic [7:0] d;
        int         startCyc;
        obsQ.delete(); expQ.delete();
        d = 8'h81;
        startCyc = cyc;
        hold(1'b0, B);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                hold(d[i], H);
                hold(~d[i], 1);
                hold(d[i], B - H - 1);
            end else begin
                hold(d[i], B);
            end
        end
        hold(1'b1, B);
        expectFrame(d, 1'b1, startCyc);
        hold(1'b1, B);
        testsRun++;
        if (obsQ.size() !== expQ.size()) begin testsFailed++; $display("[TB] FAIL spike event count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            testsRun++;
            if (obsQ[i].isErr !== expQ[i].isErr || obsQ[i].data !== expQ[i].data || obsQ[i].cyc !== expQ[i].cyc) begin
                testsFailed++;
                $display("[TB] FAIL spike event %0d: got err=%0d data=%h cyc=%0d expected err=%0d data=%h cyc=%0d",
                         i, obsQ[i].isErr, obsQ[i].data, obsQ[i].cyc, expQ[i].isErr, expQ[i].data, expQ[i].cyc);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        obsQ.delete(); expQ.delete();
        d = 8'h77;
        hold(1'b0, B);
        for (int i = 0; i < 4; i++) hold(d[i], B);
        hold(d[4], H);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lastGood = 8'h00;
        testsRun++;
        if (rxData !== 8'h00 || rxFlag !== 1'b0 || rxErr !== 1'b0 || rxBusy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset outputs: got data=%h flag=%b err=%b busy=%b expected 00/0/0/0", rxData, rxFlag, rxErr, rxBusy);
        end
        hold(1'b1, 12 * B);
        testsRun++;
        if (obsQ.size() !== 0) begin testsFailed++; $display("[TB] FAIL midreset strobes: got %0d expected 0", obsQ.size()); end
        obsQ.delete();
        applyStimulus(8'h12, 1'b1);
        hold(1'b1, B);
        testsRun++;
        if (obsQ.size() !== expQ.size()) begin testsFailed++; $display("[TB] FAIL midreset event count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            testsRun++;
            if (obsQ[i].isErr !== expQ[i].isErr || obsQ[i].data !== expQ[i].data || obsQ[i].cyc !== expQ[i].cyc) begin
                testsFailed++;
                $display("[TB] FAIL midreset event %0d: got err=%0d data=%h cyc=%0d expected err=%0d data=%h cyc=%0d",
                         i, obsQ[i].isErr, obsQ[i].data, obsQ[i].cyc, expQ[i].isErr, expQ[i].data, expQ[i].cyc);
            end
        end
    endtask

    task automatic test_random();
        logic       prevBad;
        logic [7:0] d;
        logic       stopLvl;
        int         gap;
        obsQ.delete(); expQ.delete();
        prevBad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            d       = 8'($urandom);
            stopLvl = ($urandom_range(0, 4) != 0);
            gap     = $urandom_range(0, 3);
            if (prevBad && gap == 0) gap = 1;
            if (gap > 0) hold(1'b1, gap * B);
            applyStimulus(d, stopLvl);
            prevBad = !stopLvl;
        end
        hold(1'b1, 2 * B);
        testsRun++;
        if (obsQ.size() !== expQ.size()) begin testsFailed++; $display("[TB] FAIL random event count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            testsRun++;
            if (obsQ[i].isErr !== expQ[i].isErr || obsQ[i].data !== expQ[i].data || obsQ[i].cyc !== expQ[i].cyc) begin
                testsFailed++;
                $display("[TB] FAIL random event %0d: got err=%0d data=%h cyc=%0d expected err=%0d data=%h cyc=%0d",
                         i, obsQ[i].isErr, obsQ[i].data, obsQ[i].cyc, expQ[i].isErr, expQ[i].data, expQ[i].cyc);
            end
        end
        testsRun++;
        if (rxData !== lastGood) begin testsFailed++; $display("[TB] FAIL random held data: got %h expected %h", rxData, lastGood); end
    endtask

    task automatic test_invariants();
        testsRun++;
        if (bothHigh !== 0) begin testsFailed++; $display("[TB] FAIL flag and err together: got %0d cycles expected 0", bothHigh); end
        testsRun++;
        if (spuriousData !== 0) begin testsFailed++; $display("[TB] FAIL data change without flag: got %0d expected 0", spuriousData); end
    endtask

    // Run the scenarios in order, then report
    initial begin
        test_reset();
        test_single_byte();
        test_framing_break();
        test_back_to_back();
        test_glitch();
        test_spike();
        test_mid_reset();
        test_random();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
